dout_readback_capture: RTL and testbench

- Downstream neighbour of the DIN/CLK/SYNC serial driver; captures the DUT shift-chain DOUT pin during each SYNC frame.
- Same clk_in domain as the driver. Compares captured bits against the pattern driven on DIN, then exposes the captured frame and error status for the vJTAG readout buffer.
- Replaces the LED-only observation of DOUT with a checked loopback capture.

---
 rtl/dout_readback_capture.sv | 87 ++++++++
 tb/tb_dout_readback_capture.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dout_readback_capture.sv
// dout_readback_capture: checked DOUT loopback frame capture; define DOUT_FALL_EDGE_EN to sample on the ser_clk falling edge
module dout_readback_capture #(
  parameter int N = 491,
  parameter int DLY = 0,
  parameter int ERRW = 16
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   ser_clk,
  input  logic                   ser_syn,
  input  logic                   ser_dout,
  input  logic [N-1:0]           data_ref,
  output logic [N-1:0]           cap_reg,
  output logic [$clog2(N+1):0]   bit_cnt,
  output logic [ERRW-1:0]        err_cnt,
  output logic                   done,
  output logic                   len_err,
  output logic                   busy
);
  localparam int CW = $clog2(N+1) + 1;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t st, nxt;
  logic clk_d1, clk_d2, syn_d1, syn_d2, arm_d1, arm_d2, dout_d1;
  logic smp, syn_rise, syn_fall, arm_rise, in_win, ref_bit;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt_nxt;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      {clk_d1, clk_d2, syn_d1, syn_d2, arm_d1, arm_d2, dout_d1} <= '0;
    end else begin
      {clk_d2, clk_d1} <= {clk_d1, ser_clk};
      {syn_d2, syn_d1} <= {syn_d1, ser_syn};
      {arm_d2, arm_d1} <= {arm_d1, arm};
      dout_d1 <= ser_dout;
    end
`ifdef DOUT_FALL_EDGE_EN
  assign smp = ~clk_d1 & clk_d2;
`else
  assign smp = clk_d1 & ~clk_d2;
`endif
  assign syn_rise = syn_d1 & ~syn_d2;
  assign syn_fall = ~syn_d1 & syn_d2;
  assign arm_rise = arm_d1 & ~arm_d2;
  assign busy = st == ARMED || st == CAPTURE;
  // bit_cnt is the index of the bit being sampled; only the window after the chain latency is compared
  assign in_win = int'(bit_cnt) >= DLY && int'(bit_cnt) < N + DLY;
  assign idx = IW'(N - 1 + DLY - int'(bit_cnt));
  assign ref_bit = data_ref[idx];
  assign cnt_nxt = smp && bit_cnt != '1 ? bit_cnt + 1'b1 : bit_cnt;
  always_comb begin
    nxt = st;
    nxt = (st == IDLE || st == DONE) && arm_rise ? ARMED :
          st == ARMED && syn_rise ? CAPTURE :
          st == CAPTURE && syn_fall ? DONE : st;
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      cap_reg <= '0;
      bit_cnt <= '0;
      err_cnt <= '0;
      done <= 1'b0;
      len_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == ARMED && syn_rise) begin
        cap_reg <= '0;
        bit_cnt <= '0;
        err_cnt <= '0;
        len_err <= 1'b0;
      end else if (st == CAPTURE) begin
        if (smp) begin
          cap_reg <= {cap_reg[N-2:0], dout_d1};
          bit_cnt <= cnt_nxt;
          if (in_win && dout_d1 != ref_bit && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
        if (syn_fall) begin
          done <= 1'b1;
          len_err <= cnt_nxt != CW'(N + DLY);
        end
      end
    end
endmodule

// File: tb/tb_dout_readback_capture.sv
// tb_dout_readback_capture: directed loopback frames against DLY=0 and DLY=2 instances
module tb_dout_readback_capture;
  localparam int N = 491;
  logic clk_in = 0, rst = 1, arm = 0, ser_clk = 0, ser_syn = 0, dout0 = 0, dout2 = 0;
  logic [N-1:0] dref, cap0, cap2, msk, none;
  logic [9:0] bc0, bc2;
  logic [15:0] err0, err2;
  logic done0, done2, le0, le2, busy0, busy2;
  int cmp = 0, bad = 0, nd0 = 0, nd2 = 0, s0, s2;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    if (done0) nd0++;
    if (done2) nd2++;
  end
  dout_readback_capture #(.N(N), .DLY(0), .ERRW(16)) u0 (
    .clk_in(clk_in), .rst(rst), .arm(arm), .ser_clk(ser_clk), .ser_syn(ser_syn),
    .ser_dout(dout0), .data_ref(dref), .cap_reg(cap0), .bit_cnt(bc0), .err_cnt(err0),
    .done(done0), .len_err(le0), .busy(busy0));
  dout_readback_capture #(.N(N), .DLY(2), .ERRW(16)) u2 (
    .clk_in(clk_in), .rst(rst), .arm(arm), .ser_clk(ser_clk), .ser_syn(ser_syn),
    .ser_dout(dout2), .data_ref(dref), .cap_reg(cap2), .bit_cnt(bc2), .err_cnt(err2),
    .done(done2), .len_err(le2), .busy(busy2));
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_arm();
    arm = 1;
    cyc(3);
    arm = 0;
    cyc(3);
  endtask
  task automatic frame(input int ne, input logic [N-1:0] flip, input int arm_at, input int rst_at);
    s0 = nd0;
    s2 = nd2;
    ser_syn = 1;
    cyc(4);
    for (int i = 0; i < ne; i++) begin
      if (i == rst_at) begin
        rst = 1;
        #1;
        chk("rst_cap", cap0, '0);
        chk("rst_bc", bc0, '0);
        chk("rst_err", err0, '0);
        chk("rst_flags", {done0, le0, busy0}, '0);
        cyc(1);
        rst = 0;
      end
      if (i == arm_at) arm = 1;
      dout0 = i < N ? dref[N-1-i] ^ flip[N-1-i] : 1'b0;
      dout2 = (i >= 2 && i < N + 2) ? dref[N+1-i] : 1'b0;
      cyc(2);
      ser_clk = 1;
      cyc(2);
      ser_clk = 0;
      arm = 0;
    end
    cyc(2);
    ser_syn = 0;
    cyc(8);
  endtask
  initial begin
    none = '0;
    for (int i = 0; i < N; i++) dref[i] = (i % 2 == 0);
    msk = '0;
    msk[490] = 1'b1;
    msk[390] = 1'b1;
    msk[0] = 1'b1;
    cyc(3);
    chk("reset_cap", cap0, '0);
    chk("reset_bc", bc0, '0);
    chk("reset_err", err0, '0);
    chk("reset_flags", {done0, le0, busy0}, '0);
    rst = 0;
    cyc(3);
    frame(N, none, -1, -1);
    chk("noarm_busy", busy0, 1'b0);
    chk("noarm_cap", cap0, '0);
    chk("noarm_bc", bc0, '0);
    chk("noarm_done", nd0 - s0, 0);
    do_arm();
    chk("armed_busy", busy0, 1'b1);
    frame(N, none, -1, -1);
    chk("loop_cap", cap0, dref);
    chk("loop_bc", bc0, 491);
    chk("loop_err", err0, 0);
    chk("loop_len", le0, 1'b0);
    chk("loop_done", nd0 - s0, 1);
    chk("loop_busy", busy0, 1'b0);
    chk("dly_short_len", le2, 1'b1);
    chk("dly_short_bc", bc2, 491);
    chk("dly_short_err", err2, 0);
    chk("dly_short_cap", cap2, dref >> 2);
    chk("dly_short_done", nd2 - s2, 1);
    do_arm();
    frame(N + 2, none, -1, -1);
    chk("dly_cap", cap2, dref);
    chk("dly_bc", bc2, 493);
    chk("dly_err", err2, 0);
    chk("dly_len", le2, 1'b0);
    chk("long_bc", bc0, 493);
    chk("long_err", err0, 0);
    chk("long_len", le0, 1'b1);
    do_arm();
    frame(N, msk, -1, -1);
    chk("flip_err", err0, 3);
    chk("flip_cap", cap0, dref ^ msk);
    chk("flip_len", le0, 1'b0);
    do_arm();
    frame(10, none, -1, -1);
    chk("short_bc", bc0, 10);
    chk("short_len", le0, 1'b1);
    chk("short_done", nd0 - s0, 1);
    chk("short_cap", cap0, {481'b0, 10'h2AA});
    do_arm();
    frame(N, none, -1, -1);
    chk("rearm_cap", cap0, dref);
    chk("rearm_bc", bc0, 491);
    chk("rearm_len", le0, 1'b0);
    do_arm();
    frame(0, none, -1, -1);
    chk("zero_bc", bc0, 0);
    chk("zero_len", le0, 1'b1);
    chk("zero_done", nd0 - s0, 1);
    do_arm();
    frame(N, none, 50, -1);
    chk("midarm_cap", cap0, dref);
    chk("midarm_bc", bc0, 491);
    chk("midarm_err", err0, 0);
    chk("midarm_done", nd0 - s0, 1);
    chk("midarm_busy", busy0, 1'b0);
    do_arm();
    frame(N, none, -1, 200);
    chk("postrst_done", nd0 - s0, 0);
    chk("postrst_bc", bc0, 0);
    chk("postrst_cap", cap0, '0);
    do_arm();
    frame(N, none, -1, -1);
    chk("recover_cap", cap0, dref);
    chk("recover_bc", bc0, 491);
    chk("recover_err", err0, 0);
    chk("recover_len", le0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
